// File: rtl/flash_line_cache.sv
// Read-only direct-mapped line cache in front of the SPI flash word-read controller.
// Hits answer on the next cycle with no stall; misses fill a whole line from offset 0.
module flash_line_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic [19:0] word_address,
  output logic [31:0] rdata,
  output logic        rbusy,
  input  logic        flush,
  output logic        f_rstrb,
  output logic [19:0] f_word_address,
  input  logic [31:0] f_rdata,
  input  logic        f_rbusy
);

  localparam int LW = $clog2(LINE_WORDS);
  localparam int NL = $clog2(NUM_LINES);
  localparam int TW = 20 - LW - NL;
  localparam int AW = NL + LW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_reg, state_next;

  logic [31:0]       data_mem [NUM_LINES*LINE_WORDS];
  logic [TW-1:0]     tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_reg;

  logic [19:0]       addr_reg;
  logic [LW-1:0]     cnt_reg;
  logic [19:0]       f_addr_reg;
  logic              rbusy_reg;
  logic              flush_pending_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       last_data_reg;

  // Field views of the incoming request and the latched miss address.
  logic [TW-1:0] req_tag, lat_tag;
  logic [NL-1:0] req_index, lat_index;
  logic [LW-1:0] req_offset, lat_offset;

  assign req_tag    = word_address[19 -: TW];
  assign req_index  = word_address[LW +: NL];
  assign req_offset = word_address[LW-1:0];
  assign lat_tag    = addr_reg[19 -: TW];
  assign lat_index  = addr_reg[LW +: NL];
  assign lat_offset = addr_reg[LW-1:0];

  logic access, hit, lookup_hit, miss_start;
  logic capture, last_word, flush_all;
  logic [LW-1:0] cnt_inc;

  assign hit        = valid_reg[req_index] && (tag_mem[req_index] == req_tag);
  assign access     = (state_reg == S_IDLE) && rstrb;
  // A flush on the same cycle as a strobe wins, so that access must refetch.
  assign lookup_hit = access && !flush && hit;
  assign miss_start = access && (flush || !hit);
  assign capture    = (state_reg == S_WAIT) && !f_rbusy;
  assign last_word  = capture && (cnt_reg == LW'(LINE_WORDS - 1));
  assign flush_all  = ((state_reg == S_IDLE) && flush) ||
                      ((state_reg == S_RESP) && (flush_pending_reg || flush));
  assign cnt_inc    = cnt_reg + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (miss_start) state_next = S_REQ;
      S_REQ:   state_next = S_GAP;
      S_GAP:   state_next = S_WAIT;
      S_WAIT: begin
        if (!f_rbusy) begin
          state_next = (cnt_reg == LW'(LINE_WORDS - 1)) ? S_RESP : S_REQ;
        end
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    f_rstrb        = (state_reg == S_REQ);
    f_word_address = f_addr_reg;
    rbusy          = rbusy_reg;
    rdata          = rdata_reg;
  end

  // Miss bookkeeping: latched address, word counter, flash address, stall flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg          <= '0;
      cnt_reg           <= '0;
      f_addr_reg        <= '0;
      rbusy_reg         <= 1'b0;
      flush_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (miss_start) begin
            addr_reg   <= word_address;
            cnt_reg    <= '0;
            f_addr_reg <= {word_address[19:LW], {LW{1'b0}}};
            rbusy_reg  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (flush) flush_pending_reg <= 1'b1;
          if (capture && !last_word) begin
            cnt_reg    <= cnt_inc;
            f_addr_reg <= {addr_reg[19:LW], cnt_inc};
          end
        end
        S_RESP: begin
          rbusy_reg         <= 1'b0;
          flush_pending_reg <= 1'b0;
        end
        default: begin
          if (flush) flush_pending_reg <= 1'b1;
        end
      endcase
    end
  end

  // Per-line valid bits: cleared at fill start or on flush, set on the last fill word.
  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (flush_all) begin
          valid_reg[gi] <= 1'b0;
        end else if (miss_start && (req_index == NL'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end else if (last_word && (lat_index == NL'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Data and tag storage, written only by the fill; never reset.
  logic [AW-1:0] wr_addr;
  assign wr_addr = {lat_index, cnt_reg};

  always_ff @(posedge clk) begin
    if (capture) begin
      data_mem[wr_addr] <= f_rdata;
      last_data_reg     <= f_rdata;
    end
    if (last_word) begin
      tag_mem[lat_index] <= lat_tag;
    end
  end

  // Registered read port shared by hit lookup and the post-fill response.
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic          rd_bypass;

  assign rd_en     = lookup_hit || (state_reg == S_RESP);
  assign rd_addr   = (state_reg == S_RESP) ? {lat_index, lat_offset}
                                           : {req_index, req_offset};
  // The final fill word was written on the previous edge; serve it from its capture register.
  assign rd_bypass = (state_reg == S_RESP) && (lat_offset == LW'(LINE_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (rd_en) begin
      rdata_reg <= rd_bypass ? last_data_reg : data_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_flash_line_cache.sv
// Directed bench for flash_line_cache with a behavioural flash controller
// that returns addr*3 after a programmable busy time.
module tb_flash_line_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rstrb = 1'b0;
  logic [19:0] word_address = '0;
  logic [31:0] rdata;
  logic        rbusy;
  logic        flush = 1'b0;
  logic        f_rstrb;
  logic [19:0] f_word_address;
  logic [31:0] f_rdata = '0;
  logic        f_rbusy = 1'b0;

  int checks = 0;
  int failures = 0;
  int flash_lat = 1;

  logic [19:0] addr_q [$];

  flash_line_cache dut (
    .clk            (clk),
    .reset          (reset),
    .rstrb          (rstrb),
    .word_address   (word_address),
    .rdata          (rdata),
    .rbusy          (rbusy),
    .flush          (flush),
    .f_rstrb        (f_rstrb),
    .f_word_address (f_word_address),
    .f_rdata        (f_rdata),
    .f_rbusy        (f_rbusy)
  );

  always #5 clk = ~clk;

  // Flash controller model: busy from the cycle after f_rstrb, data valid when busy drops.
  int          busy_cnt = 0;
  logic [19:0] fl_addr = '0;
  always @(posedge clk) begin
    if (f_rstrb) begin
      f_rbusy  <= 1'b1;
      busy_cnt <= flash_lat;
      fl_addr  <= f_word_address;
    end else if (f_rbusy) begin
      if (busy_cnt <= 1) begin
        f_rbusy <= 1'b0;
        f_rdata <= 32'(fl_addr) * 32'd3;
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (f_rstrb) addr_q.push_back(f_word_address);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input logic [19:0] addr);
    rstrb = 1'b1;
    word_address = addr;
    step();
    rstrb = 1'b0;
  endtask

  // mode 0: plain miss; 1: flush pulse in WAIT of word 2; 2: extra rstrb in WAIT of word 2
  task automatic fill(input string tag, input logic [19:0] addr, input logic [31:0] exp, input int mode);
    logic [19:0] base;
    bit          timed_out;
    base = {addr[19:2], 2'b00};
    addr_q.delete();
    strobe(addr);
    check({tag, "_rbusy_rise"}, 32'(rbusy), 32'd1);
    if (mode != 0) begin
      for (int i = 0; i < 1000 && addr_q.size() < 2; i++) step();
      step();
      step();
      if (mode == 1) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end else begin
        rstrb = 1'b1;
        word_address = 20'h00005;
        step();
        rstrb = 1'b0;
      end
    end
    timed_out = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!rbusy) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
    check({tag, "_rdata"}, rdata, exp);
    check({tag, "_npulses"}, 32'(addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(base + 20'(i)));
    end
    $display("miss %s addr=0x%05h rdata=0x%08h pulses=%0d", tag, addr, rdata, addr_q.size());
  endtask

  task automatic hit(input string tag, input logic [19:0] addr, input logic [31:0] exp);
    addr_q.delete();
    strobe(addr);
    check({tag, "_rbusy"}, 32'(rbusy), 32'd0);
    check({tag, "_rdata"}, rdata, exp);
    step();
    step();
    check({tag, "_npulses"}, 32'(addr_q.size()), 32'd0);
    $display("hit  %s addr=0x%05h rdata=0x%08h", tag, addr, rdata);
  endtask

  initial begin
    reset = 1'b1;
    step();
    step();
    step();
    check("rst_rbusy", 32'(rbusy), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_f_rstrb", 32'(f_rstrb), 32'd0);
    check("rst_f_addr", 32'(f_word_address), 32'd0);
    reset = 1'b0;
    step();

    flash_lat = 1;
    fill("cold", 20'h00005, 32'h0000000F, 0);
    hit("hit7", 20'h00007, 32'h00000015);
    hit("hit4", 20'h00004, 32'h0000000C);
    fill("evict", 20'h00025, 32'h0000006F, 0);
    fill("remiss", 20'h00005, 32'h0000000F, 0);

    flash_lat = 5;
    fill("flush_fill", 20'h00008, 32'h00000018, 1);
    fill("post_flush", 20'h00008, 32'h00000018, 0);
    fill("flush_other", 20'h00005, 32'h0000000F, 0);

    addr_q.delete();
    strobe(20'h00048);
    for (int i = 0; i < 1000 && addr_q.size() < 2; i++) step();
    step();
    step();
    reset = 1'b1;
    step();
    check("midrst_rbusy", 32'(rbusy), 32'd0);
    check("midrst_f_rstrb", 32'(f_rstrb), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    $display("reset mid-fill rbusy=%0d f_rstrb=%0d", rbusy, f_rstrb);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    fill("refill", 20'h00048, 32'h000000D8, 0);

    flash_lat = 40;
    fill("slow", 20'h00063, 32'h00000129, 2);
    check("slow_fbusy_done", 32'(f_rbusy), 32'd0);
    hit("slow_hit", 20'h00061, 32'h00000123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
